digit_serial_subtractor: RTL

//   Multi-cycle two's-complement subtractor, the inverse operation of the team's ripple-carry adders.

---
 rtl/digit_serial_subtractor_pkg.sv | 16 +
 rtl/digit_serial_subtractor_if.sv | 27 ++
 rtl/digit_serial_subtractor_sub_digit.sv | 22 ++
 rtl/digit_serial_subtractor.sv | 126 ++++++++++++
 4 files changed

// File: rtl/digit_serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor: FSM state encoding
// and the signed-overflow rule for a - b.
package digit_serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Signed overflow of a - b: operands of opposite sign and result sign differs from a.
   function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb ^ b_msb) & (d_msb ^ a_msb);
   endfunction

endpackage

// File: rtl/digit_serial_subtractor_if.sv
// Operand and result handshakes of the digit-serial subtractor.
// The slave modport is the subtractor side; master is the producer/consumer side.
interface digit_serial_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;
   logic             overflow;
   logic             zero;

   modport master (
      output in_valid, a, b, borrow_in, out_ready,
      input  in_ready, out_valid, diff, borrow_out, overflow, zero
   );

   modport slave (
      input  in_valid, a, b, borrow_in, out_ready,
      output in_ready, out_valid, diff, borrow_out, overflow, zero
   );
endinterface

// File: rtl/digit_serial_subtractor_sub_digit.sv
// One DIGIT-wide ripple chain of full-adder cells; the caller supplies the
// inverted subtrahend digit so that s_d = a_d - b_d - ~c_in.
module sub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_n_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out
);
   logic [DIGIT:0] c_s;

   assign c_s[0] = c_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s_d[i]   = a_d[i] ^ b_n_d[i] ^ c_s[i];
      assign c_s[i+1] = (a_d[i] & b_n_d[i]) | (c_s[i] & (a_d[i] ^ b_n_d[i]));
   end

   assign c_out = c_s[DIGIT];
endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - borrow_in, DIGIT bits per clock, LSB digit
// first, through a single sub_digit chain. Results are held until out_ready.
module digit_serial_subtractor
   import digit_serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input logic                   clk,
   input logic                   rst_n,
   digit_serial_subtractor_if.slave bus
);
   localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
   localparam int N          = WIDTH / DIGIT_SAFE;
   localparam int CNT_W      = $clog2(N + 1);

   if ((DIGIT < 1) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_bad_digit
      $error("digit_serial_subtractor: WIDTH must be a positive multiple of DIGIT");
   end

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic               carry_r;
   logic [WIDTH-1:0]   diff_r;
   logic               borrow_r;
   logic               overflow_r;
   logic               zero_r;
   logic               in_ready_r;
   logic               out_valid_r;

   logic [DIGIT-1:0]   a_d_s;
   logic [DIGIT-1:0]   b_d_s;
   logic [DIGIT-1:0]   s_d_s;
   logic               c_out_s;
   logic [WIDTH-1:0]   diff_next_s;

   // Select the operand digits addressed by the counter (AND-OR mux, no priority).
   always_comb begin
      a_d_s = {DIGIT{1'b0}};
      b_d_s = {DIGIT{1'b0}};
      for (int i = 0; i < N; i++) begin
         a_d_s = a_d_s | (a_r[i*DIGIT +: DIGIT] & {DIGIT{cnt_r == CNT_W'(i)}});
         b_d_s = b_d_s | (b_r[i*DIGIT +: DIGIT] & {DIGIT{cnt_r == CNT_W'(i)}});
      end
   end

   sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
      .a_d   (a_d_s),
      .b_n_d (~b_d_s),
      .c_in  (carry_r),
      .s_d   (s_d_s),
      .c_out (c_out_s)
   );

   // Result with the current digit merged in; on the last digit this is the full difference.
   always_comb begin
      diff_next_s = diff_r;
      for (int i = 0; i < N; i++) begin
         diff_next_s[i*DIGIT +: DIGIT] = (cnt_r == CNT_W'(i)) ? s_d_s : diff_r[i*DIGIT +: DIGIT];
      end
   end

   // Control FSM plus operand, result and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         carry_r     <= 1'b0;
         diff_r      <= {WIDTH{1'b0}};
         borrow_r    <= 1'b0;
         overflow_r  <= 1'b0;
         zero_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  a_r        <= bus.a;
                  b_r        <= bus.b;
                  carry_r    <= ~bus.borrow_in;
                  cnt_r      <= {CNT_W{1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               diff_r  <= diff_next_s;
               carry_r <= c_out_s;
               cnt_r   <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(N - 1)) begin
                  borrow_r    <= ~c_out_s;
                  overflow_r  <= sub_overflow(a_r[WIDTH-1], b_r[WIDTH-1], diff_next_s[WIDTH-1]);
                  zero_r      <= (diff_next_s == {WIDTH{1'b0}});
                  out_valid_r <= 1'b1;
                  state_r     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               cnt_r       <= {CNT_W{1'b0}};
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.diff       = diff_r;
   assign bus.borrow_out = borrow_r;
   assign bus.overflow   = overflow_r;
   assign bus.zero       = zero_r;
endmodule
